// File: rtl/pc_round_sequencer.sv
// pC round-constant stepper for the ASCON permutation: XORs UNROLL round constants
// per cycle into one lane of a 320-bit state, with valid/ready framing of the job.
module pc_round_sequencer #(
  parameter int UNROLL     = 1,
  parameter int CONST_LANE = 2
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [319:0] state_i,
  input  logic [3:0]   nrounds_i,
  input  logic         abort_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o
);

  localparam int         LANE_LSB = CONST_LANE * 64;
  localparam logic [3:0] UNROLL_W = 4'(UNROLL);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_t;

  fsm_t       fsm;
  logic [3:0] remaining;
  logic [3:0] step_k;
  logic [3:0] n_req;

  function automatic logic [7:0] round_constant(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  // Slots at or beyond k are masked, so the index never runs past round 11.
  function automatic logic [7:0] const_xor(input logic [3:0] first, input logic [3:0] k);
    logic [7:0] acc;
    acc = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (4'(u) < k) acc ^= round_constant(first + 4'(u));
    end
    return acc;
  endfunction

  always_comb begin
    step_k = (remaining < UNROLL_W) ? remaining : UNROLL_W;
    n_req  = ((nrounds_i == 4'd0) || (nrounds_i > 4'd12)) ? 4'd12 : nrounds_i;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm         <= IDLE;
      state_o     <= '0;
      round_o     <= '0;
      remaining   <= '0;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid_i && in_ready_o && !abort_i) begin
            state_o    <= state_i;
            round_o    <= 4'd12 - n_req;
            remaining  <= n_req;
            fsm        <= RUN;
            busy_o     <= 1'b1;
            in_ready_o <= 1'b0;
          end
        end
        RUN: begin
          if (abort_i) begin
            fsm        <= IDLE;
            round_o    <= '0;
            remaining  <= '0;
            busy_o     <= 1'b0;
            in_ready_o <= 1'b1;
          end else begin
            state_o[LANE_LSB +: 8] <= state_o[LANE_LSB +: 8] ^ const_xor(round_o, step_k);
            round_o   <= round_o + step_k;
            remaining <= remaining - step_k;
            if (remaining == step_k) begin
              fsm         <= HOLD;
              busy_o      <= 1'b0;
              out_valid_o <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (abort_i || out_ready_i) begin
            fsm         <= IDLE;
            round_o     <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: begin
          fsm         <= IDLE;
          round_o     <= '0;
          remaining   <= '0;
          busy_o      <= 1'b0;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_round_sequencer.sv
// Scoreboard bench for pc_round_sequencer: UNROLL=1 and UNROLL=4 instances side by side.
module tb_pc_round_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [1:0][319:0]   state_in, state_out;
  logic [1:0][3:0]     nrounds, round;

  pc_round_sequencer #(.UNROLL(1), .CONST_LANE(2)) u_dut1 (
    .clock_i(clk), .resetb_i(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .state_i(state_in[0]), .nrounds_i(nrounds[0]), .abort_i(abort[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .state_o(state_out[0]),
    .round_o(round[0]), .busy_o(busy[0]));

  pc_round_sequencer #(.UNROLL(4), .CONST_LANE(2)) u_dut4 (
    .clock_i(clk), .resetb_i(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .state_i(state_in[1]), .nrounds_i(nrounds[1]), .abort_i(abort[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .state_o(state_out[1]),
    .round_o(round[1]), .busy_o(busy[1]));

  typedef struct {
    logic [319:0] st;
    int           lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc[2];
  logic [1:0] prev_vld = 2'b00;
  exp_t mon_e;

  localparam logic [319:0] PAT = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                  64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978,
                                  64'h8899aabbccddeeff};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] with_byte(input logic [319:0] s, input logic [7:0] b);
    logic [319:0] m;
    m = '0;
    m[135:128] = b;
    return s ^ m;
  endfunction

  // Monitor: pop one expectation on every rising out_valid.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (out_valid[d] === 1'b1 && prev_vld[d] === 1'b0) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output dut%0d: got state %h expected no output", d, state_out[d]);
        end else begin
          if (d == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("result_state dut%0d", d), state_out[d], mon_e.st);
          chk($sformatf("latency dut%0d", d), 320'(cyc - accept_cyc[d]), 320'(mon_e.lat));
        end
      end
    end
    prev_vld <= out_valid;
  end

  task automatic run_job(input int d, input logic [319:0] s, input logic [3:0] nr,
                         input logic [7:0] exp_byte, input int exp_lat, input int hold,
                         input bit inject);
    exp_t e;
    int   u, n, r, waited;
    logic [319:0] exp_st;
    u = (d == 0) ? 1 : 4;
    n = (nr == 4'd0 || nr > 4'd12) ? 12 : int'(nr);
    r = 12 - n;
    exp_st = with_byte(s, exp_byte);
    @(negedge clk);
    in_valid[d] = 1'b1;
    state_in[d] = s;
    nrounds[d]  = nr;
    @(posedge clk);
    #1;
    accept_cyc[d] = cyc;
    e.st = exp_st;
    e.lat = exp_lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    in_valid[d] = inject;
    state_in[d] = ~s;
    for (int i = 0; i < exp_lat; i++) begin
      @(negedge clk);
      chk($sformatf("round_run dut%0d i%0d", d, i), 320'(round[d]), 320'(r));
      chk($sformatf("busy_run dut%0d", d), 320'(busy[d]), 320'(1));
      chk($sformatf("in_ready_run dut%0d", d), 320'(in_ready[d]), 320'(0));
      r += u;
    end
    in_valid[d] = 1'b0;
    waited = 0;
    @(negedge clk);
    while (out_valid[d] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (out_valid[d] !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid_timeout dut%0d: got 0 expected 1", d);
    end
    chk($sformatf("round_hold dut%0d", d), 320'(round[d]), 320'(12));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("valid_stable dut%0d", d), 320'(out_valid[d]), 320'(1));
      chk($sformatf("state_stable dut%0d", d), state_out[d], exp_st);
      chk($sformatf("in_ready_hold dut%0d", d), 320'(in_ready[d]), 320'(0));
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk($sformatf("valid_drop dut%0d", d), 320'(out_valid[d]), 320'(0));
    chk($sformatf("in_ready_back dut%0d", d), 320'(in_ready[d]), 320'(1));
    chk($sformatf("round_idle dut%0d", d), 320'(round[d]), 320'(0));
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk($sformatf("%s in_ready dut%0d", tag, d), 320'(in_ready[d]), 320'(1));
    chk($sformatf("%s out_valid dut%0d", tag, d), 320'(out_valid[d]), 320'(0));
    chk($sformatf("%s busy dut%0d", tag, d), 320'(busy[d]), 320'(0));
    chk($sformatf("%s round dut%0d", tag, d), 320'(round[d]), 320'(0));
    chk($sformatf("%s state dut%0d", tag, d), state_out[d], 320'(0));
  endtask

  initial begin
    in_valid = '0; abort = '0; out_ready = '0;
    state_in = '0; nrounds = '0;
    accept_cyc[0] = 0; accept_cyc[1] = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals(0, "reset");
    chk_reset_vals(1, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // UNROLL=1 vectors: hand-computed lane2 byte
    run_job(0, 320'(0), 4'd12, 8'h00, 12, 0, 1'b0);
    run_job(0, 320'(0), 4'd1,  8'h4b, 1,  0, 1'b0);
    run_job(0, 320'(0), 4'd3,  8'h78, 3,  0, 1'b0);
    run_job(0, 320'(0), 4'd6,  8'h11, 6,  0, 1'b0);
    run_job(0, PAT,     4'd0,  8'h00, 12, 0, 1'b0);
    run_job(0, PAT,     4'd15, 8'h00, 12, 0, 1'b0);
    run_job(0, PAT,     4'd3,  8'h78, 3,  2, 1'b1);

    // UNROLL=4 vectors, including partial last step
    run_job(1, 320'(0), 4'd6,  8'h11, 2, 0, 1'b0);
    run_job(1, PAT,     4'd6,  8'h11, 2, 5, 1'b0);
    run_job(1, PAT,     4'd8,  8'h00, 2, 0, 1'b0);
    run_job(1, PAT,     4'd12, 8'h00, 3, 0, 1'b0);
    run_job(1, PAT,     4'd3,  8'h78, 1, 0, 1'b0);
    run_job(1, 320'(0), 4'd1,  8'h4b, 1, 0, 1'b0);

    // abort during RUN cycle 3 of pa: rounds 0,1 applied (0xf0^0xe1)
    @(negedge clk);
    in_valid[0] = 1'b1; state_in[0] = PAT; nrounds[0] = 4'd12;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort in_ready", 320'(in_ready[0]), 320'(1));
    chk("abort busy", 320'(busy[0]), 320'(0));
    chk("abort round", 320'(round[0]), 320'(0));
    chk("abort state_kept", state_out[0], with_byte(PAT, 8'h11));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort no_valid", 320'(out_valid[0]), 320'(0));
    end

    // abort in IDLE blocks an accept
    in_valid[0] = 1'b1; abort[0] = 1'b1; nrounds[0] = 4'd2;
    @(negedge clk);
    in_valid[0] = 1'b0; abort[0] = 1'b0;
    chk("idle_abort busy", 320'(busy[0]), 320'(0));
    chk("idle_abort in_ready", 320'(in_ready[0]), 320'(1));

    // async reset mid-RUN
    in_valid[0] = 1'b1; state_in[0] = PAT; nrounds[0] = 4'd12;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0, "midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset in_ready", 320'(in_ready[0]), 320'(1));
    chk("post_reset busy", 320'(busy[0]), 320'(0));
    run_job(0, 320'(0), 4'd3, 8'h78, 3, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue0_empty", 320'(q0.size()), 320'(0));
    chk("queue1_empty", 320'(q1.size()), 320'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1, "timeout");
  end

endmodule
